// File: rtl/sha256_id_pkg.sv
// Shared defaults and entry type for the SHA-256 ID broadcast FIFO.
package sha256_id_pkg;

    localparam int ID_W_DEF    = 6;
    localparam int DEPTH_DEF   = 4;
    localparam int NUM_OUT_DEF = 2;

    typedef struct packed {
        logic [ID_W_DEF-1:0] id;
        logic                last;
    } id_entry_t;

endpackage

// File: rtl/sha256_id_fifo_mem.sv
// Entry storage for sha256_id_fifo: one synchronous write port, asynchronous read, no reset.
module sha256_id_fifo_mem
    import sha256_id_pkg::*;
#(
    parameter int  DEPTH   = DEPTH_DEF,
    parameter type entry_t = id_entry_t
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  entry_t                   wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output entry_t                   rd_data
);

    entry_t mem_r [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/sha256_id_fifo.sv
// ID FIFO whose head is broadcast to NUM_OUT consumers; the head retires once every
// consumer has accepted it, in any order.
module sha256_id_fifo
    import sha256_id_pkg::*;
#(
    parameter int ID_W    = ID_W_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int NUM_OUT = NUM_OUT_DEF
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic                       en,
    input  logic                       sync_rst,
    input  logic [ID_W-1:0]            id_in,
    input  logic                       id_in_last,
    input  logic                       id_in_valid,
    output logic                       id_in_ready,
    output logic [ID_W-1:0]            id_out,
    output logic                       id_out_last,
    output logic [NUM_OUT-1:0]         id_out_valid,
    input  logic [NUM_OUT-1:0]         id_out_ready,
    output logic [ID_W-1:0]            status_id,
    output logic                       status_last,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic            last;
    } entry_t;

    logic [PW-1:0]      wr_ptr_r;
    logic [PW-1:0]      rd_ptr_r;
    logic [CW-1:0]      count_r;
    logic [NUM_OUT-1:0] taken_r;
    entry_t             status_r;
    entry_t             wr_entry_s;
    entry_t             head_s;
    logic [NUM_OUT-1:0] hs_s;
    logic               nonempty_s;
    logic               push_s;
    logic               retire_s;

    assign nonempty_s = (count_r != '0);
    assign wr_entry_s = '{id: id_in, last: id_in_last};

    // Handshake availability; everything is held off while disabled or in reset
    always_comb begin
        if (nrst && en) begin
            id_in_ready  = (count_r < DEPTH_C);
            id_out_valid = nonempty_s ? ~taken_r : '0;
        end else begin
            id_in_ready  = 1'b0;
            id_out_valid = '0;
        end
    end

    assign hs_s     = id_out_valid & id_out_ready;
    assign push_s   = id_in_valid & id_in_ready;
    // Retire when every channel has either already taken the head or takes it now
    assign retire_s = en & nonempty_s & (&(taken_r | hs_s));

    sha256_id_fifo_mem #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push_s & ~sync_rst),
        .wr_addr (wr_ptr_r),
        .wr_data (wr_entry_s),
        .rd_addr (rd_ptr_r),
        .rd_data (head_s)
    );

    // Head entry is forced to zero while reset is asserted
    always_comb begin
        if (nrst) begin
            id_out      = head_s.id;
            id_out_last = head_s.last;
        end else begin
            id_out      = '0;
            id_out_last = 1'b0;
        end
    end

    // Pointers, occupancy, per-channel taken flags and retired-entry status
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            taken_r  <= '0;
            status_r <= '0;
        end else if (sync_rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            taken_r  <= '0;
            status_r <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1'b1);
            end
            if (retire_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1'b1);
                taken_r  <= '0;
                status_r <= head_s;
            end else begin
                taken_r  <= taken_r | hs_s;
            end
            case ({push_s, retire_s})
                2'b10:   count_r <= count_r + CW'(1'b1);
                2'b01:   count_r <= count_r - CW'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign status_id   = status_r.id;
    assign status_last = status_r.last;
    assign count       = count_r;

endmodule

// File: tb/tb_sha256_id_fifo.sv
// Scoreboard bench for sha256_id_fifo at default parameters (ID_W=6, DEPTH=4, NUM_OUT=2).
module tb_sha256_id_fifo;

    logic       clk = 1'b0;
    logic       nrst, en, sync_rst;
    logic [5:0] id_in, id_out, status_id;
    logic       id_in_last, id_in_valid, id_in_ready, id_out_last, status_last;
    logic [1:0] id_out_valid, id_out_ready;
    logic [2:0] count;

    always #5 clk = ~clk;

    sha256_id_fifo dut (
        .clk(clk), .nrst(nrst), .en(en), .sync_rst(sync_rst),
        .id_in(id_in), .id_in_last(id_in_last),
        .id_in_valid(id_in_valid), .id_in_ready(id_in_ready),
        .id_out(id_out), .id_out_last(id_out_last),
        .id_out_valid(id_out_valid), .id_out_ready(id_out_ready),
        .status_id(status_id), .status_last(status_last), .count(count)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit lat_chk = 1'b0;
    int rdy_mode = 0;
    int stall   = 0;

    typedef struct {
        logic [6:0] e;
        int         cyc;
    } ment_t;

    ment_t      q_m[$];
    logic [6:0] rx0[$];
    logic [6:0] rx1[$];
    logic [1:0] m_taken  = 2'b00;
    logic [6:0] m_status = 7'h00;
    int         m_cnt;
    logic [1:0] m_valid, m_hs;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare outputs with the model, then advance the model for the coming edge
    always @(negedge clk) begin
        if (!nrst) begin
            chk("rst_in_ready", 32'(id_in_ready), 32'd0);
            chk("rst_out_valid", 32'(id_out_valid), 32'd0);
            chk("rst_id_out", 32'({id_out_last, id_out}), 32'd0);
            chk("rst_count", 32'(count), 32'd0);
            chk("rst_status", 32'({status_last, status_id}), 32'd0);
            q_m.delete();
            m_taken  = 2'b00;
            m_status = 7'h00;
        end else begin
            m_cnt   = q_m.size();
            m_valid = (en && m_cnt > 0) ? ~m_taken : 2'b00;
            chk("count", 32'(count), 32'(m_cnt));
            chk("in_ready", 32'(id_in_ready), 32'(en && (m_cnt < 4)));
            chk("out_valid", 32'(id_out_valid), 32'(m_valid));
            chk("status", 32'({status_last, status_id}), 32'(m_status));
            if (m_cnt > 0) chk("head", 32'({id_out_last, id_out}), 32'(q_m[0].e));
            if (sync_rst) begin
                q_m.delete();
                m_taken  = 2'b00;
                m_status = 7'h00;
            end else if (en) begin
                m_hs = m_valid & id_out_ready;
                if (m_hs[0]) begin
                    rx0.push_back(q_m[0].e);
                    if (lat_chk) chk("latency0", 32'(cyc - q_m[0].cyc), 32'd1);
                end
                if (m_hs[1]) begin
                    rx1.push_back(q_m[0].e);
                    if (lat_chk) chk("latency1", 32'(cyc - q_m[0].cyc), 32'd1);
                end
                if (m_cnt > 0 && (&(m_taken | m_hs))) begin
                    m_status = q_m[0].e;
                    void'(q_m.pop_front());
                    m_taken = 2'b00;
                end else begin
                    m_taken = m_taken | m_hs;
                end
                if (id_in_valid && m_cnt < 4) q_m.push_back('{e: {id_in_last, id_in}, cyc: cyc});
            end
        end
        cyc++;
    end

    // Consumer ready generator for the skewed and random modes
    always @(posedge clk) begin
        #1;
        if (rdy_mode == 1) begin
            id_out_ready[0] = 1'b1;
            if (id_out_ready[1]) begin
                id_out_ready[1] = 1'b0;
                stall = 0;
            end else if (id_out_valid[1]) begin
                stall++;
                if (stall == 3) id_out_ready[1] = 1'b1;
            end
        end else if (rdy_mode == 2) begin
            id_out_ready = 2'($urandom_range(0, 3));
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_id(input logic [5:0] id, input logic last);
        bit acc = 1'b0;
        id_in       = id;
        id_in_last  = last;
        id_in_valid = 1'b1;
        for (int t = 0; t < 300 && !acc; t++) begin
            @(negedge clk);
            if (id_in_ready) acc = 1'b1;
        end
        @(posedge clk);
        #1;
        id_in_valid = 1'b0;
        chk("push_accept", 32'(acc), 32'd1);
    endtask

    task automatic wait_empty();
        for (int t = 0; t < 500; t++) begin
            @(negedge clk);
            if (count == 3'd0) break;
        end
        chk("drain_count", 32'(count), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_logs(input string name, input logic [6:0] exp[$]);
        chk({name, "_n0"}, 32'(rx0.size()), 32'(exp.size()));
        chk({name, "_n1"}, 32'(rx1.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            if (i < rx0.size()) chk({name, "_ch0"}, 32'(rx0[i]), 32'(exp[i]));
            if (i < rx1.size()) chk({name, "_ch1"}, 32'(rx1[i]), 32'(exp[i]));
        end
        rx0.delete();
        rx1.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] exp_q[$];
        nrst = 1'b0; en = 1'b1; sync_rst = 1'b0;
        id_in = 6'd0; id_in_last = 1'b0; id_in_valid = 1'b0; id_out_ready = 2'b00;
        repeat (3) @(posedge clk);
        #1 nrst = 1'b1;
        idle(1);

        // Back-to-back pushes with both channels always ready
        id_out_ready = 2'b11;
        lat_chk = 1'b1;
        push_id(6'd5, 1'b0);
        push_id(6'd6, 1'b0);
        push_id(6'd7, 1'b1);
        wait_empty();
        lat_chk = 1'b0;
        chk("t037_status_id", 32'(status_id), 32'd7);
        chk("t037_status_last", 32'(status_last), 32'd1);
        exp_q = '{7'h05, 7'h06, 7'h47};
        check_logs("t037", exp_q);

        // Fill to DEPTH; a fifth ID waits for the first retire
        id_out_ready = 2'b00;
        for (int i = 0; i < 4; i++) push_id(6'(10 + i), 1'b0);
        @(negedge clk);
        chk("t038_full_count", 32'(count), 32'd4);
        chk("t038_full_ready", 32'(id_in_ready), 32'd0);
        @(posedge clk);
        #1;
        fork
            push_id(6'd14, 1'b1);
        join_none
        idle(3);
        id_out_ready = 2'b11;
        wait_empty();
        idle(1);
        exp_q = '{7'h0A, 7'h0B, 7'h0C, 7'h0D, 7'h4E};
        check_logs("t038", exp_q);

        // ch1 stalls 3 cycles per entry
        id_out_ready = 2'b00;
        rdy_mode = 1;
        push_id(6'd20, 1'b0);
        push_id(6'd21, 1'b0);
        push_id(6'd22, 1'b1);
        wait_empty();
        rdy_mode = 0;
        id_out_ready = 2'b00;
        exp_q = '{7'h14, 7'h15, 7'h56};
        check_logs("t039", exp_q);

        // Same-edge push and retire at count 2, then a disabled window
        push_id(6'd30, 1'b0);
        push_id(6'd31, 1'b0);
        id_out_ready = 2'b11;
        id_in = 6'd32; id_in_last = 1'b1; id_in_valid = 1'b1;
        @(posedge clk);
        #1;
        id_in_valid = 1'b0;
        id_out_ready = 2'b00;
        @(negedge clk);
        chk("t041_count", 32'(count), 32'd2);
        chk("t041_status", 32'(status_id), 32'd30);
        @(posedge clk);
        #1;
        en = 1'b0;
        id_out_ready = 2'b11;
        idle(3);
        chk("t041_en0_count", 32'(count), 32'd2);
        en = 1'b1;
        wait_empty();
        id_out_ready = 2'b00;
        exp_q = '{7'h1E, 7'h1F, 7'h60};
        check_logs("t041", exp_q);

        // Wrap: IDs 0..9 with random gaps and random consumer stalls
        rdy_mode = 2;
        for (int i = 0; i < 10; i++) begin
            idle($urandom_range(0, 2));
            push_id(6'(i), (i == 9));
        end
        wait_empty();
        rdy_mode = 0;
        id_out_ready = 2'b00;
        exp_q = '{7'h00, 7'h01, 7'h02, 7'h03, 7'h04, 7'h05, 7'h06, 7'h07, 7'h08, 7'h49};
        check_logs("t040", exp_q);

        // Synchronous clear with three entries and ch0 already holding the head
        push_id(6'd40, 1'b0);
        push_id(6'd41, 1'b0);
        push_id(6'd42, 1'b1);
        id_out_ready = 2'b01;
        @(posedge clk);
        #1;
        sync_rst = 1'b1;
        id_out_ready = 2'b11;
        id_in = 6'd43; id_in_last = 1'b0; id_in_valid = 1'b1;
        @(posedge clk);
        #1;
        sync_rst = 1'b0;
        id_in_valid = 1'b0;
        id_out_ready = 2'b00;
        @(negedge clk);
        chk("t042_count", 32'(count), 32'd0);
        chk("t042_valid", 32'(id_out_valid), 32'd0);
        chk("t042_status", 32'({status_last, status_id}), 32'd0);
        chk("t042_ch0_took", 32'(rx0.size()), 32'd1);
        rx0.delete();
        rx1.delete();
        @(posedge clk);
        #1;
        id_out_ready = 2'b11;
        push_id(6'd9, 1'b1);
        wait_empty();
        exp_q = '{7'h49};
        check_logs("t042", exp_q);

        // Asynchronous reset with entries in flight
        id_out_ready = 2'b00;
        push_id(6'd50, 1'b0);
        push_id(6'd51, 1'b1);
        nrst = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 nrst = 1'b1;
        @(negedge clk);
        chk("post_rst_count", 32'(count), 32'd0);
        chk("post_rst_valid", 32'(id_out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sha256_id_fifo.md
SHA256_ID_FIFO -- requirements
Module: sha256_id_fifo

Interface
REQ-001 Parameter ID_W SHALL default to 6 and set the ID width in bits.
REQ-002 Parameter DEPTH SHALL default to 4 and set FIFO entries; legal values are powers of 2, >=2.
REQ-003 Parameter NUM_OUT SHALL default to 2 and set the number of broadcast consumer channels; legal range is 1..8.
REQ-004 clk  in  1  clock; all state SHALL update on its rising edge.
REQ-005 nrst  in  1  reset, asynchronous, active-low.
REQ-006 en  in  1  block enable.
REQ-007 sync_rst  in  1  synchronous clear.
REQ-008 id_in  in  ID_W  ID being pushed.
REQ-009 id_in_last  in  1  last-ID-of-packet flag.
REQ-010 id_in_valid / id_in_ready  in / out  1 / 1  push handshake.
REQ-011 id_out  out  ID_W  head-entry ID, shared by all channels.
REQ-012 id_out_last  out  1  head-entry last flag.
REQ-013 id_out_valid / id_out_ready  out / in  NUM_OUT / NUM_OUT  per-channel pop handshake.
REQ-014 status_id  out  ID_W  ID of the most recently retired entry.
REQ-015 status_last  out  1  last flag of the most recently retired entry.
REQ-016 count  out  $clog2(DEPTH+1)  current occupancy.

Function
REQ-017 A push SHALL occur on an edge where id_in_valid and id_in_ready are both 1.
REQ-018 id_in_ready SHALL be en && (count < DEPTH); no write-through when full, even with a simultaneous retire.
REQ-019 A pushed entry SHALL first be visible on id_out/id_out_valid one cycle after the push edge (latency 1).
REQ-020 id_out_valid[i] SHALL be en && (count > 0) && !taken[i].
REQ-021 taken[i] is a per-channel flag, set on channel i's handshake edge and held until retire.
REQ-022 The head SHALL retire on the edge where every channel i has taken[i]=1 or handshakes that edge.
REQ-023 On retire: read pointer +1 mod DEPTH; all taken[] clear; status_id/status_last load the head entry.
REQ-024 Channels SHALL accept the head in any order and on any cycle; each channel receives each entry exactly once.
REQ-025 On the same edge, a push and a retire SHALL leave count unchanged and both pointers advanced.
REQ-026 Pointers SHALL wrap modulo DEPTH; full/empty SHALL be derived from count, not pointer equality.
REQ-027 id_out/id_out_last SHALL hold the head entry while count>0; when empty they SHALL hold their last value, don't-care to checkers.
REQ-028 When en=0: id_in_ready=0 and all id_out_valid=0, so no push/pop occurs, while contents, taken[], status and count hold.
REQ-029 When sync_rst=1: on the next edge pointers, count and taken[] SHALL clear and status_id/status_last SHALL go to 0; sync_rst overrides any same-edge handshake; entry storage need not clear.
REQ-030 id_in_last SHALL be stored and forwarded only; it SHALL NOT alter FIFO behaviour.

Reset
REQ-031 With nrst=0, all control state SHALL clear asynchronously: pointers, count, taken[], status_id=0, status_last=0.
REQ-032 During reset id_in_ready=0 and id_out_valid=0; reset mid-transfer SHALL discard all entries.
REQ-033 id_out and id_out_last SHALL read 0 during reset.

Structure
REQ-034 Package sha256_id_pkg SHALL hold the ID_W/DEPTH/NUM_OUT defaults and typedef id_entry_t {id, last}.
REQ-035 Storage SHALL be sub-module sha256_id_fifo_mem: DEPTH x id_entry_t, 1 write port, async read, no reset.
REQ-036 Control (pointers, count, taken[], status) SHALL reside in sha256_id_fifo.

Verification
REQ-037 Defaults, all ready=1: push IDs 5,6,7(last) back-to-back -> both channels emit 5,6,7 in order, each 1 cycle after push; status_id ends 7, status_last=1.
REQ-038 Fill: push 4 IDs, out ready=0 -> count=4, id_in_ready=0; a 5th valid ID is held and enters only after the first retire.
REQ-039 Skewed consumers: ch0 ready always, ch1 stalls 3 cycles per entry -> ch0 sees each ID once, no retire until ch1 takes it, status updates only on ch1's handshake.
REQ-040 Wrap: 10 IDs 0..9 with random gaps and stalls -> outputs 0..9 on every channel, count never >4 or <0.
REQ-041 Same-edge push+retire at count=2 -> count stays 2, order preserved.
REQ-042 sync_rst with 3 entries and ch0 mid-take -> next cycle count=0, all valid=0, status_id=0; a subsequent push of ID 9 emerges first on both channels.
